// File: rtl/uc_pkg.sv
// Shared definitions for the microcontroller core: opcode map, instruction
// sequencer states and fault causes.
package uc_pkg;

  // Opcode map (instr[15:12])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction-cycle states
  typedef enum logic [2:0] {
    S_IDLE,
    S_F_ADDR,
    S_F_MEM,
    S_F_IR,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } seq_state_t;

  // Fault causes reported on fault_code
  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // One-hot enable for a 4-bit opcode
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-instruction watchdog: 8-bit counter cleared before each EXEC phase and
// advanced once per EXEC cycle. expired is high during the EXEC cycle whose
// increment brings the count to TIMEOUT, so a fault lands on the following edge.
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // Count EXEC cycles; saturate so a long stall can never wrap back to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-cycle controller: fetches over the shared bus, decodes the
// opcode, hands the bus to the selected execute FSM and waits for its done.
module instr_sequencer
  import uc_pkg::*;
#(
  parameter int          TIMEOUT   = 15,
  parameter logic [15:0] VALID_OPS = 16'h807F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic [15:0] done_vec,
  output logic        IF_active,
  output logic        PC_out,
  output logic        MAR_in,
  output logic        mem_rd,
  output logic        IR_in,
  output logic [15:0] exec_en,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] retired
);

  seq_state_t  state, state_nxt;
  logic [3:0]  opc;
  logic [1:0]  fc_nxt;
  logic [15:0] retired_q;
  logic        retire;
  logic        wd_clear, wd_en, wd_expired;
  logic        instr_unused;

  // Only the opcode field matters here; operands belong to the execute FSMs
  assign instr_unused = ^instr[11:0];
  assign retired      = retired_q;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // State register, latched opcode, fault cause and retirement counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      opc        <= 4'h0;
      fault_code <= FC_NONE;
      retired_q  <= 16'h0000;
    end else begin
      state      <= state_nxt;
      fault_code <= fc_nxt;
      if (state == S_DECODE) opc <= instr[15:12];
      if (retire) retired_q <= retired_q + 16'h0001;
    end
  end

  // Next-state logic and Moore outputs; exec_en also uses the latched opcode
  always_comb begin
    state_nxt = state;
    fc_nxt    = fault_code;
    retire    = 1'b0;
    wd_clear  = 1'b0;
    wd_en     = 1'b0;
    IF_active = 1'b1;
    PC_out    = 1'b0;
    MAR_in    = 1'b0;
    mem_rd    = 1'b0;
    IR_in     = 1'b0;
    exec_en   = 16'h0000;
    busy      = 1'b1;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_nxt = S_F_ADDR;
      end
      S_F_ADDR: begin
        PC_out    = 1'b1;
        MAR_in    = 1'b1;
        state_nxt = S_F_MEM;
      end
      S_F_MEM: begin
        mem_rd = 1'b1;
        if (mem_ready) state_nxt = S_F_IR;
      end
      S_F_IR: begin
        mem_rd    = 1'b1;
        IR_in     = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        wd_clear = 1'b1;
        if (instr[15:12] == OP_HALT) begin
          state_nxt = S_HALT;
        end else if (!VALID_OPS[instr[15:12]]) begin
          state_nxt = S_FAULT;
          fc_nxt    = FC_ILLEGAL;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        IF_active = 1'b0;
        wd_en     = 1'b1;
        exec_en   = onehot16(opc);
        if (done_vec[opc]) begin
          retire    = 1'b1;
          state_nxt = run ? S_F_ADDR : S_IDLE;
        end else if (wd_expired) begin
          state_nxt = S_FAULT;
          fc_nxt    = FC_TIMEOUT;
        end
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      S_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-scenario tasks with a
// retirement scoreboard filled at issue and drained at completion.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, mem_ready;
  logic [15:0] instr, done_vec;
  logic        IF_active, PC_out, MAR_in, mem_rd, IR_in, busy, halted, fault;
  logic [15:0] exec_en, retired;
  logic [1:0]  fault_code;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] model_retired = 16'h0000;
  logic [15:0] sb_q[$];

  // Expected {IF_active,PC_out,MAR_in,mem_rd,IR_in,busy,halted,fault} per state
  localparam logic [7:0] ST_IDLE   = 8'b1000_0000;
  localparam logic [7:0] ST_F_ADDR = 8'b1110_0100;
  localparam logic [7:0] ST_F_MEM  = 8'b1001_0100;
  localparam logic [7:0] ST_F_IR   = 8'b1001_1100;
  localparam logic [7:0] ST_DECODE = 8'b1000_0100;
  localparam logic [7:0] ST_EXEC   = 8'b0000_0100;
  localparam logic [7:0] ST_HALT   = 8'b1000_0010;
  localparam logic [7:0] ST_FAULT  = 8'b1000_0001;

  instr_sequencer #(.TIMEOUT(15), .VALID_OPS(16'h807F)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .done_vec   (done_vec),
    .IF_active  (IF_active),
    .PC_out     (PC_out),
    .MAR_in     (MAR_in),
    .mem_rd     (mem_rd),
    .IR_in      (IR_in),
    .exec_en    (exec_en),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .fault_code (fault_code),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL time_limit simulation did not finish within 200000 time units");
    $fatal(1, "[TB] time limit");
  end

  function automatic logic [7:0] ctl();
    return {IF_active, PC_out, MAR_in, mem_rd, IR_in, busy, halted, fault};
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_dut();
    run = 1'b0; mem_ready = 1'b0; done_vec = 16'h0000; instr = 16'h0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_retired = 16'h0000;
    sb_q.delete();
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
  endtask

  // Drive one fetch + decode starting in F_ADDR; returns mem_rd cycles seen in F_MEM
  task automatic fetch(input logic [15:0] ir, input int waits, output int rd_cycles);
    checks++;
    if (ctl() !== ST_F_ADDR) begin
      failures++; $display("[TB] FAIL fetch_addr ctl got %b want %b", ctl(), ST_F_ADDR);
    end
    instr = ir;
    tick();
    rd_cycles = 0;
    for (int w = 0; w <= waits; w++) begin
      mem_ready = (w == waits);
      checks++;
      if (ctl() !== ST_F_MEM) begin
        failures++; $display("[TB] FAIL fetch_mem ctl got %b want %b", ctl(), ST_F_MEM);
      end
      if (mem_rd) rd_cycles++;
      tick();
    end
    mem_ready = 1'b0;
    checks++;
    if (ctl() !== ST_F_IR) begin
      failures++; $display("[TB] FAIL fetch_ir ctl got %b want %b", ctl(), ST_F_IR);
    end
    tick();
    checks++;
    if (ctl() !== ST_DECODE) begin
      failures++; $display("[TB] FAIL decode ctl got %b want %b", ctl(), ST_DECODE);
    end
    tick();
  endtask

  // Run an EXEC phase that completes with done in cycle done_at
  task automatic exec_done(input int done_at, input bit run_after, input bit stray,
                           input logic [15:0] exp_en);
    logic [15:0] exp_ret;
    model_retired = model_retired + 16'h0001;
    sb_q.push_back(model_retired);
    for (int c = 1; c <= done_at; c++) begin
      checks++;
      if (ctl() !== ST_EXEC) begin
        failures++; $display("[TB] FAIL exec_state cycle %0d ctl got %b want %b", c, ctl(), ST_EXEC);
      end
      checks++;
      if (exec_en !== exp_en) begin
        failures++; $display("[TB] FAIL exec_en cycle %0d got %h want %h", c, exec_en, exp_en);
      end
      done_vec = (c == done_at) ? exp_en : (stray ? 16'h0008 : 16'h0000);
      if (c == 2 && !run_after) run = 1'b0;
      if (c == done_at) run = run_after;
      tick();
    end
    done_vec = 16'h0000;
    exp_ret = sb_q.pop_front();
    checks++;
    if (retired !== exp_ret) begin
      failures++; $display("[TB] FAIL retired got %h want %h", retired, exp_ret);
    end
    checks++;
    if (ctl() !== (run_after ? ST_F_ADDR : ST_IDLE)) begin
      failures++; $display("[TB] FAIL exec_exit ctl got %b want %b", ctl(),
                           run_after ? ST_F_ADDR : ST_IDLE);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; done_vec = 16'h0000; instr = 16'h0000;
    tick();
    checks++;
    if (ctl() !== ST_IDLE) begin
      failures++; $display("[TB] FAIL reset_ctl got %b want %b", ctl(), ST_IDLE);
    end
    checks++;
    if ({exec_en, fault_code, retired} !== 34'h0) begin
      failures++; $display("[TB] FAIL reset_regs exec_en=%h fault_code=%b retired=%h want 0",
                           exec_en, fault_code, retired);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ctl() !== ST_IDLE) begin
      failures++; $display("[TB] FAIL idle_no_run ctl got %b want %b", ctl(), ST_IDLE);
    end
  endtask

  task automatic test_mov();
    int rd, t0;
    start_run();
    t0 = cyc;
    fetch(16'h6042, 0, rd);
    exec_done(3, 1'b1, 1'b0, 16'h0040);
    checks++;
    if (cyc - t0 != 7) begin
      failures++; $display("[TB] FAIL mov_period got %0d want 7", cyc - t0);
    end
  endtask

  task automatic test_mem_wait();
    int rd, t0;
    t0 = cyc;
    fetch(16'h6042, 3, rd);
    checks++;
    if (rd != 4) begin
      failures++; $display("[TB] FAIL mem_rd_wait got %0d want 4", rd);
    end
    exec_done(3, 1'b0, 1'b0, 16'h0040);
    checks++;
    if (cyc - t0 != 10) begin
      failures++; $display("[TB] FAIL wait_period got %0d want 10", cyc - t0);
    end
  endtask

  task automatic test_stray_run_drop();
    int rd;
    start_run();
    fetch(16'h6042, 0, rd);
    exec_done(5, 1'b0, 1'b1, 16'h0040);
  endtask

  task automatic test_done_at_limit();
    int rd;
    start_run();
    fetch(16'h6042, 0, rd);
    exec_done(15, 1'b0, 1'b0, 16'h0040);
  endtask

  task automatic test_reset_mid();
    int rd;
    start_run();
    instr = 16'h6042;
    mem_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (ctl() !== ST_F_MEM) begin
      failures++; $display("[TB] FAIL stall_mem ctl got %b want %b", ctl(), ST_F_MEM);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ctl(), exec_en, fault_code, retired} !== {ST_IDLE, 34'h0}) begin
      failures++; $display("[TB] FAIL rst_mid_fetch ctl=%b exec_en=%h fc=%b retired=%h want %b/0/0/0",
                           ctl(), exec_en, fault_code, retired, ST_IDLE);
    end
    tick();
    rst = 1'b0;
    run = 1'b0;
    model_retired = 16'h0000;
    sb_q.delete();
    start_run();
    fetch(16'h6042, 0, rd);
    rst = 1'b1;
    #1;
    checks++;
    if ({IF_active, exec_en} !== {1'b1, 16'h0000}) begin
      failures++; $display("[TB] FAIL rst_mid_exec IF_active=%b exec_en=%h want 1/0000", IF_active, exec_en);
    end
    tick();
    rst = 1'b0;
    run = 1'b0;
  endtask

  task automatic test_wrap();
    int rd;
    force dut.retired_q = 16'hFFFF;
    tick();
    release dut.retired_q;
    model_retired = 16'hFFFF;
    tick();
    checks++;
    if (retired !== 16'hFFFF) begin
      failures++; $display("[TB] FAIL preload got %h want FFFF", retired);
    end
    start_run();
    fetch(16'h6042, 0, rd);
    exec_done(3, 1'b0, 1'b0, 16'h0040);
  endtask

  task automatic test_halt();
    int rd;
    reset_dut();
    start_run();
    fetch(16'hF000, 0, rd);
    checks++;
    if (ctl() !== ST_HALT) begin
      failures++; $display("[TB] FAIL halt_entry ctl got %b want %b", ctl(), ST_HALT);
    end
    done_vec = 16'hFFFF;
    repeat (3) tick();
    done_vec = 16'h0000;
    checks++;
    if ({ctl(), retired, exec_en} !== {ST_HALT, model_retired, 16'h0000}) begin
      failures++; $display("[TB] FAIL halt_hold ctl=%b retired=%h exec_en=%h", ctl(), retired, exec_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ctl() !== ST_IDLE) begin
      failures++; $display("[TB] FAIL halt_reset ctl got %b want %b", ctl(), ST_IDLE);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_illegal();
    int rd;
    reset_dut();
    start_run();
    fetch(16'h9ABC, 0, rd);
    checks++;
    if ({ctl(), fault_code} !== {ST_FAULT, 2'b01}) begin
      failures++; $display("[TB] FAIL illegal ctl=%b fc=%b want %b/01", ctl(), fault_code, ST_FAULT);
    end
    done_vec = 16'hFFFF;
    repeat (3) tick();
    done_vec = 16'h0000;
    checks++;
    if ({ctl(), fault_code} !== {ST_FAULT, 2'b01}) begin
      failures++; $display("[TB] FAIL illegal_hold ctl=%b fc=%b want %b/01", ctl(), fault_code, ST_FAULT);
    end
  endtask

  task automatic test_timeout();
    int rd;
    reset_dut();
    start_run();
    fetch(16'h6042, 0, rd);
    for (int c = 1; c <= 15; c++) begin
      checks++;
      if (ctl() !== ST_EXEC) begin
        failures++; $display("[TB] FAIL timeout_wait cycle %0d ctl got %b want %b", c, ctl(), ST_EXEC);
      end
      done_vec = 16'hFFBF;
      tick();
    end
    done_vec = 16'h0000;
    checks++;
    if ({ctl(), fault_code, retired} !== {ST_FAULT, 2'b10, model_retired}) begin
      failures++; $display("[TB] FAIL timeout ctl=%b fc=%b retired=%h want %b/10/%h",
                           ctl(), fault_code, retired, ST_FAULT, model_retired);
    end
  endtask

  initial begin
    test_reset();
    test_mov();
    test_mem_wait();
    test_stray_run_drop();
    test_done_at_limit();
    test_reset_mid();
    test_wrap();
    test_halt();
    test_illegal();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Top-level instruction-cycle controller for the microcontroller core. Drives the fetch phase on the shared internal bus, decodes the IR opcode, hands the bus to the matching per-opcode execute FSM (MOV, ADD, …) by dropping `IF_active`, then waits for that FSM's `done` pulse. Supervises each instruction with a watchdog and flags illegal opcodes and HALT.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum EXEC cycles without the selected `done` before a fault; must be 1–255.
- `VALID_OPS`, 16'h807F: legal-opcode mask; bit n set means opcode n is legal. Opcode 4'hF is always HALT, regardless of the mask.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `run`  in  1  level; enables instruction issue.
- `instr`  in  16  IR contents; opcode is `instr[15:12]`.
- `mem_ready`  in  1  memory read data valid.
- `done_vec`  in  16  per-opcode execute-FSM done pulses; bit n comes from the opcode-n FSM.
- `IF_active`  out  1  high outside EXEC; holds every execute FSM in its idle state.
- `PC_out`  out  1  PC drives the bus.
- `MAR_in`  out  1  MAR loads from the bus.
- `mem_rd`  out  1  memory read strobe.
- `IR_in`  out  1  IR loads from the memory data bus.
- `exec_en`  out  16  one-hot enable for the opcode being executed.
- `busy`  out  1  high in every state except IDLE, HALT and FAULT.
- `halted`  out  1  high in HALT.
- `fault`  out  1  high in FAULT.
- `fault_code`  out  2  fault cause: 01 = illegal opcode, 10 = timeout; 00 otherwise.
- `retired`  out  16  count of completed instructions; wraps.

## Operation
- All outputs are Moore-decoded from the state register, except `exec_en`, which is decoded from the state register plus the latched opcode.
- States and transitions:
  - IDLE: go to F_ADDR if `run`=1.
  - F_ADDR: assert `PC_out` and `MAR_in`; go to F_MEM.
  - F_MEM: assert `mem_rd`; hold until `mem_ready`=1, then go to F_IR.
  - F_IR: assert `mem_rd` and `IR_in`; go to DECODE.
  - DECODE: latch `opc`=`instr[15:12]`.
    - opc=F: go to HALT.
    - `VALID_OPS[opc]`=0: go to FAULT with code 01.
    - Otherwise: clear the watchdog and go to EXEC.
  - EXEC: `IF_active`=0 and `exec_en[opc]`=1.
    - `done_vec[opc]`=1: increment `retired`, then go to F_ADDR if `run`=1, else IDLE.
    - Watchdog reaches `TIMEOUT` without that done: go to FAULT with code 10.
  - HALT and FAULT: terminal, exit only by `rst`. `fault_code` holds its value while in FAULT.
- `done_vec` bits other than `opc` are ignored in every state. `done_vec` is ignored outside EXEC.
- If done and timeout occur in the same cycle, done wins.
- `run` dropping mid-instruction does not abort. The sequencer finishes the current instruction and stops at the fetch boundary. `run` is sampled only in IDLE and on the EXEC exit.
- `retired` is 16-bit, wraps FFFF→0000, and is not cleared by HALT or FAULT.
- Watchdog: 8-bit counter, cleared in DECODE, incremented each EXEC cycle.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, `IF_active`=1, `retired`=0, `fault_code`=00, `opc`=0.
  - All other outputs 0.
- Fetch with zero-wait memory (`mem_ready` high in F_MEM): 3 cycles (F_ADDR, F_MEM, F_IR). Each extra wait cycle adds 1.
- DECODE: 1 cycle. `IF_active` falls on the clock edge entering EXEC.
- The execute FSM sees `IF_active`=0 at its first edge in EXEC. A 4-state FSM like MOV pulses done in the 3rd EXEC cycle.
- Back-to-back issue: the edge that samples done moves the sequencer to F_ADDR. `IF_active` is high in that cycle, so the execute FSM resets.
- Minimum instruction period is 4 + N cycles for an N-cycle EXEC. MOV is 7 cycles.
- A timeout fault enters FAULT on the edge after EXEC cycle `TIMEOUT` (counter value `TIMEOUT`, no done).
- `rst` mid-EXEC returns to IDLE immediately and forces `IF_active`=1, which also resets the execute FSMs.

## Structure
- Shared package `uc_pkg`:
  - opcode constants (OP_MOV=4'h6, OP_HALT=4'hF, …)
  - sequencer state enum
  - fault-code constants
- One sub-module, `seq_watchdog`, containing the 8-bit counter with clear, enable and `expired` output.
- Everything else is one FSM plus the `retired` counter.

## Test plan
- Reset, then `run`=1, IR=16'h6042 (MOV), zero-wait memory, `done_vec[6]` pulsed in the 3rd EXEC cycle → F_ADDR, F_MEM, F_IR, DECODE, 3×EXEC; `exec_en`=16'h0040; `retired`=1; next F_ADDR follows immediately.
- Same instruction with `mem_ready` delayed 3 cycles → `mem_rd` high 4 cycles in F_MEM; total period 10 cycles; `retired`=1.
- IR=16'hF000 → HALT after DECODE; `halted`=1, `busy`=0; `done_vec`=FFFF has no effect; `rst` returns to IDLE.
- Opcode 4'h9 with the default mask → FAULT with `fault_code`=01. Opcode 6 with no done for 15 EXEC cycles → FAULT with `fault_code`=10. Done on cycle 15 exactly → completes with no fault.
- Stray `done_vec[3]` during a MOV EXEC → ignored, sequencer stays in EXEC. `run` dropped during EXEC → instruction completes, sequencer goes to IDLE.
- Preload 16'hFFFF retirements via the force path → the next completion wraps `retired` to 0. Assert `rst` mid-F_MEM → IDLE with all outputs at their reset values.
